// File: rtl/hazard_pool_controller.sv
// hazard_pool_controller
// Lethal-pool controller: checks both player boxes against a fixed pool table
// and runs a per-player ALIVE -> SINKING -> DEAD state machine.
// Build option: define HAZARD_GRACE_EN to enable the frame-gated grace period.
// Without it the legacy behaviour applies: any lethal overlap on any cycle
// kills the player, and frame_tick is ignored.
module hazard_pool_controller #(
    parameter int         POOL_COUNT             = 3,
    parameter shortint    POOL_X    [POOL_COUNT] = '{296, 424, 392},
    parameter shortint    POOL_Y    [POOL_COUNT] = '{463, 463, 366},
    parameter logic [1:0] POOL_TYPE [POOL_COUNT] = '{2'd0, 2'd1, 2'd2},
    parameter int         POOL_W                 = 80,
    parameter int         POOL_H                 = 5,
    parameter int         GRACE_FRAMES           = 2,
    localparam int        KW = (POOL_COUNT > 1) ? $clog2(POOL_COUNT) : 1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_tick,
    input  logic               level_restart,
    input  logic               freeze,
    input  logic signed [15:0] player1_top,
    input  logic signed [15:0] player1_bottom,
    input  logic signed [15:0] player1_left,
    input  logic signed [15:0] player1_right,
    input  logic signed [15:0] player2_top,
    input  logic signed [15:0] player2_bottom,
    input  logic signed [15:0] player2_left,
    input  logic signed [15:0] player2_right,
    output logic [1:0]         player_dead,
    output logic [1:0]         dead_pulse,
    output logic [1:0]         sinking,
    output logic [2*KW-1:0]    killer_idx,
    output logic               any_dead,
    output logic [3:0]         state_dbg
);

    typedef enum logic [1:0] {
        ST_ALIVE   = 2'd0,
        ST_SINKING = 2'd1,
        ST_DEAD    = 2'd2
    } state_t;

    state_t        state_q  [2];
    state_t        state_d  [2];
    logic [KW-1:0] killer_q [2];
    logic [KW-1:0] killer_d [2];
    logic [1:0]    pulse_q;
    logic [1:0]    pulse_d;
`ifdef HAZARD_GRACE_EN
    logic [3:0]    cnt_q    [2];
    logic [3:0]    cnt_d    [2];
`else
    logic          unused_tick;
    localparam int unused_grace = GRACE_FRAMES;
    assign unused_tick = frame_tick;
`endif

    logic signed [15:0] box_top   [2];
    logic signed [15:0] box_bottom[2];
    logic signed [15:0] box_left  [2];
    logic signed [15:0] box_right [2];
    logic [1:0]         hit;
    logic [KW-1:0]      first     [2];

    assign box_top[0]    = player1_top;
    assign box_bottom[0] = player1_bottom;
    assign box_left[0]   = player1_left;
    assign box_right[0]  = player1_right;
    assign box_top[1]    = player2_top;
    assign box_bottom[1] = player2_bottom;
    assign box_left[1]   = player2_left;
    assign box_right[1]  = player2_right;

    // 17-bit signed overlap test; pool far edges are widened before the add so
    // pools near the top of the coordinate range cannot wrap negative.
    function automatic logic pool_lethal(input int p, input int i,
                                         input logic signed [15:0] t,
                                         input logic signed [15:0] b,
                                         input logic signed [15:0] l,
                                         input logic signed [15:0] r);
        logic signed [16:0] x_lo, x_hi, y_lo, y_hi;
        logic signed [16:0] t17, b17, l17, r17;
        logic               ov;
        x_lo = {POOL_X[i][15], POOL_X[i]};
        y_lo = {POOL_Y[i][15], POOL_Y[i]};
        x_hi = x_lo + 17'(POOL_W);
        y_hi = y_lo + 17'(POOL_H);
        t17  = {t[15], t};
        b17  = {b[15], b};
        l17  = {l[15], l};
        r17  = {r[15], r};
        ov   = (r17 > x_lo) && (l17 < x_hi) && (b17 > y_lo) && (t17 < y_hi);
        // Player p (0-based) is immune to pool type p; type 3 is disabled.
        return ov && (POOL_TYPE[i] != 2'd3) && (POOL_TYPE[i] != 2'(p));
    endfunction

    // Per-player hit flag and lowest-index lethal pool (scan high to low so
    // the lowest index is the last writer).
    always_comb begin
        hit      = '0;
        first[0] = '0;
        first[1] = '0;
        for (int p = 0; p < 2; p++) begin
            for (int i = POOL_COUNT - 1; i >= 0; i--) begin
                if (pool_lethal(p, i, box_top[p], box_bottom[p],
                                box_left[p], box_right[p])) begin
                    hit[p]   = 1'b1;
                    first[p] = KW'(i);
                end
            end
        end
    end

    // State registers for both players.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int p = 0; p < 2; p++) begin
                state_q[p]  <= ST_ALIVE;
                killer_q[p] <= '0;
`ifdef HAZARD_GRACE_EN
                cnt_q[p]    <= '0;
`endif
            end
            pulse_q <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                state_q[p]  <= state_d[p];
                killer_q[p] <= killer_d[p];
`ifdef HAZARD_GRACE_EN
                cnt_q[p]    <= cnt_d[p];
`endif
            end
            pulse_q <= pulse_d;
        end
    end

    // Next-state logic: restart beats freeze beats normal evaluation.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            state_d[p]  = state_q[p];
            killer_d[p] = killer_q[p];
`ifdef HAZARD_GRACE_EN
            cnt_d[p]    = cnt_q[p];
`endif
        end
        pulse_d = '0;
        for (int p = 0; p < 2; p++) begin
            if (level_restart) begin
                state_d[p]  = ST_ALIVE;
                killer_d[p] = '0;
`ifdef HAZARD_GRACE_EN
                cnt_d[p]    = '0;
`endif
            end else if (!freeze) begin
`ifdef HAZARD_GRACE_EN
                if (frame_tick) begin
                    case (state_q[p])
                        ST_ALIVE: begin
                            if (hit[p]) begin
                                if (GRACE_FRAMES == 0) begin
                                    state_d[p]  = ST_DEAD;
                                    killer_d[p] = first[p];
                                    pulse_d[p]  = 1'b1;
                                end else begin
                                    state_d[p] = ST_SINKING;
                                    cnt_d[p]   = 4'd1;
                                end
                            end
                        end
                        ST_SINKING: begin
                            if (!hit[p]) begin
                                state_d[p] = ST_ALIVE;
                                cnt_d[p]   = '0;
                            end else if (cnt_q[p] >= 4'(GRACE_FRAMES)) begin
                                state_d[p]  = ST_DEAD;
                                killer_d[p] = first[p];
                                pulse_d[p]  = 1'b1;
                            end else begin
                                cnt_d[p] = cnt_q[p] + 4'd1;
                            end
                        end
                        default: ;
                    endcase
                end
`else
                if (state_q[p] != ST_DEAD && hit[p]) begin
                    state_d[p]  = ST_DEAD;
                    killer_d[p] = first[p];
                    pulse_d[p]  = 1'b1;
                end
`endif
            end
        end
    end

    // Outputs decode registered state only.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            player_dead[p] = (state_q[p] == ST_DEAD);
`ifdef HAZARD_GRACE_EN
            sinking[p]     = (state_q[p] == ST_SINKING);
`else
            sinking[p]     = 1'b0;
`endif
        end
        dead_pulse = pulse_q;
        killer_idx = {killer_q[1], killer_q[0]};
        any_dead   = |player_dead;
        state_dbg  = {state_q[1], state_q[0]};
    end

endmodule
